// File: rtl/l2_responder_pkg.sv
// Shared widths, FSM encoding and address-field helpers for the L2 responder.
package l2_responder_pkg;

  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    WDONE
  } l2_state_e;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int off_w(input int lines);
    return (lines > 0) ? $clog2(LINE_WORDS) : 0;
  endfunction

  // Byte offset within a line is word offset plus the 2 byte-select bits.
  function automatic int tag_w(input int lines);
    return ADDR_W - (off_w(lines) + 2) - idx_w(lines);
  endfunction

endpackage

// File: rtl/l2_line_store.sv
// Valid/tag/data array: combinational read port, one write port (full-line fill or single word).
// Zero-latency reads; writes land on the rising edge; no backpressure.
module l2_line_store
  import l2_responder_pkg::*;
#(
  parameter int LINES = 16,
  localparam int IW = idx_w(LINES),
  localparam int TW = tag_w(LINES),
  localparam int OW = off_w(LINES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [IW-1:0]                         rd_idx_i,
  output logic                                  rd_vld_o,
  output logic [TW-1:0]                         rd_tag_o,
  output logic [LINE_WORDS-1:0][WORD_W-1:0]     rd_line_o,
  input  logic                                  wr_en_i,
  input  logic                                  wr_full_i,
  input  logic [IW-1:0]                         wr_idx_i,
  input  logic [TW-1:0]                         wr_tag_i,
  input  logic [OW-1:0]                         wr_word_i,
  input  logic [LINE_WORDS-1:0][WORD_W-1:0]     wr_line_i,
  input  logic [WORD_W-1:0]                     wr_dat_i
);

  logic [LINES-1:0]                     valid_q;
  logic [TW-1:0]                        tag_q  [LINES];
  logic [LINE_WORDS-1:0][WORD_W-1:0]    data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en_i && wr_full_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data are left unreset: valid_q gates every hit.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (wr_full_i) begin
        tag_q[wr_idx_i]  <= wr_tag_i;
        data_q[wr_idx_i] <= wr_line_i;
      end else begin
        data_q[wr_idx_i][wr_word_i] <= wr_dat_i;
      end
    end
  end

  assign rd_vld_o  = valid_q[rd_idx_i];
  assign rd_tag_o  = tag_q[rd_idx_i];
  assign rd_line_o = data_q[rd_idx_i];

endmodule

// File: rtl/l2_responder.sv
// Direct-mapped write-through L2: read hits in 0 cycles, misses fill 4 DRAM beats, writes take one DRAM beat + WDONE.
// stallL2 holds the L1 requester (which keeps mem_addr/mem_wdata stable) until its request is served.
module l2_responder
  import l2_responder_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_renable,
  input  logic                 mem_wenable,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [WORD_W-1:0]    mem_wdata,
  output logic [0:127]         l1block,
  output logic [WORD_W-1:0]    mem_rdata,
  output logic                 stallL2,
  output logic                 dram_req,
  output logic                 dram_we,
  output logic [ADDR_W-1:0]    dram_addr,
  output logic [WORD_W-1:0]    dram_wdata,
  input  logic [WORD_W-1:0]    dram_rdata,
  input  logic                 dram_ack
);

  localparam int IW      = idx_w(LINES);
  localparam int TW      = tag_w(LINES);
  localparam int OW      = off_w(LINES);
  localparam int BLK_LSB = OW + 2;

  l2_state_e                            state_q, state_d;
  logic [OW-1:0]                        beat_q, beat_d;
  logic [LINE_WORDS-2:0][WORD_W-1:0]    fill_q, fill_d;

  logic [IW-1:0]                        addr_idx;
  logic [TW-1:0]                        addr_tag;
  logic [OW-1:0]                        addr_word;
  logic                                 rd_vld;
  logic [TW-1:0]                        rd_tag;
  logic [LINE_WORDS-1:0][WORD_W-1:0]    rd_line;
  logic                                 hit;
  logic                                 stall_c;
  logic                                 wr_en;
  logic                                 wr_full;

  assign addr_idx  = mem_addr[BLK_LSB+IW-1:BLK_LSB];
  assign addr_tag  = mem_addr[ADDR_W-1:BLK_LSB+IW];
  assign addr_word = mem_addr[BLK_LSB-1:2];

  l2_line_store #(
    .LINES (LINES)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (addr_idx),
    .rd_vld_o  (rd_vld),
    .rd_tag_o  (rd_tag),
    .rd_line_o (rd_line),
    .wr_en_i   (wr_en),
    .wr_full_i (wr_full),
    .wr_idx_i  (addr_idx),
    .wr_tag_i  (addr_tag),
    .wr_word_i (addr_word),
    .wr_line_i ({dram_rdata, fill_q}),
    .wr_dat_i  (mem_wdata)
  );

  assign hit = rd_vld && (rd_tag == addr_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    fill_d     = fill_q;
    stall_c    = 1'b0;
    dram_req   = 1'b0;
    dram_we    = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    wr_en      = 1'b0;
    wr_full    = 1'b0;
    case (state_q)
      IDLE: begin
        // Read wins over a simultaneous write; the write is simply not taken this cycle.
        if (mem_renable) begin
          if (!hit) begin
            stall_c = 1'b1;
            state_d = FILL;
            beat_d  = '0;
          end
        end else if (mem_wenable) begin
          stall_c = 1'b1;
          state_d = WRITE;
        end
      end
      FILL: begin
        stall_c   = 1'b1;
        dram_req  = 1'b1;
        dram_addr = {mem_addr[ADDR_W-1:BLK_LSB], beat_q, 2'b00};
        if (dram_ack) begin
          if (beat_q == OW'(LINE_WORDS - 1)) begin
            wr_en   = 1'b1;
            wr_full = 1'b1;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            fill_d[beat_q] = dram_rdata;
            beat_d         = beat_q + 1'b1;
          end
        end
      end
      WRITE: begin
        stall_c    = 1'b1;
        dram_req   = 1'b1;
        dram_we    = 1'b1;
        dram_addr  = mem_addr;
        dram_wdata = mem_wdata;
        if (dram_ack) begin
          wr_en   = hit;
          state_d = WDONE;
        end
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A request held through reset must not show as a stall.
  assign stallL2   = rst && stall_c;
  assign l1block   = hit ? {rd_line[0], rd_line[1], rd_line[2], rd_line[3]} : '0;
  assign mem_rdata = hit ? rd_line[addr_word] : '0;

endmodule

// File: tb/tb_l2_responder.sv
// Directed table plus randomized traffic against a line-level cache/DRAM reference model.
module tb_l2_responder;

  localparam int LINES = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mem_renable = 1'b0;
  logic         mem_wenable = 1'b0;
  logic [31:0]  mem_addr = '0;
  logic [31:0]  mem_wdata = '0;
  logic [0:127] l1block;
  logic [31:0]  mem_rdata;
  logic         stallL2;
  logic         dram_req;
  logic         dram_we;
  logic [31:0]  dram_addr;
  logic [31:0]  dram_wdata;
  logic [31:0]  dram_rdata = '0;
  logic         dram_ack = 1'b0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] rd_log[$];
  logic [31:0] dram_mem[logic [31:0]];
  int          dram_lat = 2;
  bit          dram_auto = 1'b1;

  bit          ref_vld[LINES];
  logic [31:0] ref_tag[LINES];
  logic [31:0] ref_dat[LINES][4];
  logic [31:0] ref_mem[logic [31:0]];

  l2_responder #(.LINES(LINES)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_renable (mem_renable),
    .mem_wenable (mem_wenable),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .l1block     (l1block),
    .mem_rdata   (mem_rdata),
    .stallL2     (stallL2),
    .dram_req    (dram_req),
    .dram_we     (dram_we),
    .dram_addr   (dram_addr),
    .dram_wdata  (dram_wdata),
    .dram_rdata  (dram_rdata),
    .dram_ack    (dram_ack)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] dram_init(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // DRAM: acks a held request after dram_lat cycles.
  initial begin : dram_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!dram_auto) begin
        cnt = 0;
      end else if (dram_ack) begin
        dram_ack = 1'b0;
        cnt = 0;
      end else if (dram_req) begin
        cnt++;
        if (cnt >= dram_lat) begin
          dram_ack   = 1'b1;
          dram_rdata = dram_mem.exists(dram_addr) ? dram_mem[dram_addr] : dram_init(dram_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : dram_logger
    forever begin
      @(posedge clk);
      if (rst && dram_req && dram_ack) begin
        if (dram_we) begin
          n_wr++;
          dram_mem[dram_addr] = dram_wdata;
        end else begin
          n_rd++;
          rd_log.push_back(dram_addr);
        end
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dram_init(a);
  endfunction

  task automatic ref_read(input logic [31:0] a, output bit hit, output logic [31:0] d,
                          output logic [127:0] blk);
    int          idx;
    logic [31:0] tag;
    idx = int'((a / 16) % LINES);
    tag = a / (16 * LINES);
    hit = ref_vld[idx] && (ref_tag[idx] == tag);
    if (!hit) begin
      ref_vld[idx] = 1'b1;
      ref_tag[idx] = tag;
      for (int w = 0; w < 4; w++) ref_dat[idx][w] = ref_word((a & ~32'hF) + 32'(4 * w));
    end
    d   = ref_dat[idx][(a / 4) % 4];
    blk = {ref_dat[idx][0], ref_dat[idx][1], ref_dat[idx][2], ref_dat[idx][3]};
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd);
    int idx;
    idx = int'((a / 16) % LINES);
    ref_mem[a] = wd;
    if (ref_vld[idx] && ref_tag[idx] == a / (16 * LINES)) ref_dat[idx][(a / 4) % 4] = wd;
  endtask

  // Called at a negedge; returns at a later negedge with the request dropped.
  task automatic run_tx(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output bit first_stall, output logic [31:0] rdata, output logic [127:0] blk,
                        output int nrd, output int nwr, output int lbase);
    int rd0, wr0, k;
    rd0 = n_rd;
    wr0 = n_wr;
    lbase = rd_log.size();
    mem_renable = rd;
    mem_wenable = wr;
    mem_addr    = addr;
    mem_wdata   = wd;
    #1;
    first_stall = stallL2;
    k = 0;
    while (stallL2 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("served", stallL2, 1'b0);
    chk("req_when_served", dram_req, 1'b0);
    rdata = mem_rdata;
    blk   = l1block;
    @(negedge clk);
    mem_renable = 1'b0;
    mem_wenable = 1'b0;
    nrd = n_rd - rd0;
    nwr = n_wr - wr0;
  endtask

  task automatic model_tx(input string name, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd);
    bit          hit, fs;
    logic [31:0] ed, d;
    logic [127:0] eb, b;
    int          nrd, nwr, lb;
    hit = 1'b0;
    ed  = '0;
    eb  = '0;
    if (rd) ref_read(addr, hit, ed, eb);
    run_tx(rd, wr, addr, wd, fs, d, b, nrd, nwr, lb);
    if (!rd && wr) ref_write(addr, wd);
    chk({name, "_stall0"}, fs, !(rd && hit));
    chk({name, "_nrd"}, nrd, (rd && !hit) ? 4 : 0);
    chk({name, "_nwr"}, nwr, (!rd && wr) ? 1 : 0);
    if (rd) begin
      chk({name, "_rdata"}, d, ed);
      chk({name, "_blk"}, b, eb);
    end
  endtask

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  wd;
    bit           exp_stall;
    int           exp_nrd;
    int           exp_nwr;
    logic [31:0]  exp_rdata;
    logic [127:0] exp_blk;
  } vec_t;

  function automatic vec_t mkv(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wd, input bit es, input int enr, input int enw,
                               input logic [31:0] erd, input logic [127:0] eb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.exp_stall = es; v.exp_nrd = enr; v.exp_nwr = enw; v.exp_rdata = erd; v.exp_blk = eb;
    return v;
  endfunction

  function automatic logic [127:0] blk_of(input logic [31:0] base, input logic [31:0] w1_override,
                                          input bit use_ovr);
    return {dram_init(base), use_ovr ? w1_override : dram_init(base + 4),
            dram_init(base + 8), dram_init(base + 12)};
  endfunction

  initial begin : main
    vec_t         vecs[9];
    bit           fs;
    logic [31:0]  d;
    logic [127:0] b;
    int           nrd, nwr, lb, k;

    vecs[0] = mkv(1, 0, 32'h40, 0, 1, 4, 0, dram_init(32'h40), blk_of(32'h40, 0, 0));
    vecs[1] = mkv(1, 0, 32'h48, 0, 0, 0, 0, dram_init(32'h48), blk_of(32'h40, 0, 0));
    vecs[2] = mkv(0, 1, 32'h44, 32'hDEADBEEF, 1, 0, 1, 0, 0);
    vecs[3] = mkv(1, 0, 32'h44, 0, 0, 0, 0, 32'hDEADBEEF, blk_of(32'h40, 32'hDEADBEEF, 1));
    vecs[4] = mkv(0, 1, 32'h1000_0000, 32'h1234_5678, 1, 0, 1, 0, 0);
    vecs[5] = mkv(1, 0, 32'h1000_0000, 0, 1, 4, 0, 32'h1234_5678,
                  {32'h1234_5678, dram_init(32'h1000_0004), dram_init(32'h1000_0008),
                   dram_init(32'h1000_000C)});
    vecs[6] = mkv(1, 0, 32'h440, 0, 1, 4, 0, dram_init(32'h440), blk_of(32'h440, 0, 0));
    vecs[7] = mkv(1, 0, 32'h40, 0, 1, 4, 0, dram_init(32'h40), blk_of(32'h40, 32'hDEADBEEF, 1));
    vecs[8] = mkv(1, 1, 32'h4C, 32'h0BAD_0BAD, 0, 0, 0, dram_init(32'h4C),
                  blk_of(32'h40, 32'hDEADBEEF, 1));

    // Reset with a read request held: nothing may stall or reach DRAM.
    mem_renable = 1'b1;
    mem_addr    = 32'h40;
    #12;
    chk("rst_stall", stallL2, 1'b0);
    chk("rst_req", dram_req, 1'b0);
    chk("rst_we", dram_we, 1'b0);
    chk("rst_daddr", dram_addr, 32'h0);
    chk("rst_wdata", dram_wdata, 32'h0);
    chk("rst_blk", l1block, 128'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    mem_renable = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      bit          hh;
      logic [31:0] ed;
      logic [127:0] eb;
      if (vecs[i].rd) ref_read(vecs[i].addr, hh, ed, eb);
      run_tx(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, fs, d, b, nrd, nwr, lb);
      if (!vecs[i].rd && vecs[i].wr) ref_write(vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_stall0", i), fs, vecs[i].exp_stall);
      chk($sformatf("vec%0d_nrd", i), nrd, vecs[i].exp_nrd);
      chk($sformatf("vec%0d_nwr", i), nwr, vecs[i].exp_nwr);
      if (vecs[i].rd) begin
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_blk", i), b, vecs[i].exp_blk);
      end
      if (vecs[i].exp_nrd == 4 && nrd == 4) begin
        for (int j = 0; j < 4; j++)
          chk($sformatf("vec%0d_fill_addr%0d", i, j), rd_log[lb + j],
              (vecs[i].addr & ~32'hF) + 32'(4 * j));
      end
    end

    // Write held across WDONE: WDONE lasts one cycle, then the held write is taken again.
    k = n_wr;
    mem_wenable = 1'b1;
    mem_addr    = 32'h48;
    mem_wdata   = 32'hCAFE_F00D;
    #1;
    nrd = 0;
    while (stallL2 && nrd < 200) begin @(negedge clk); #1; nrd++; end
    chk("wdone_stall", stallL2, 1'b0);
    chk("wdone_req", dram_req, 1'b0);
    @(negedge clk);
    #1;
    chk("wdone_one_cycle", stallL2, 1'b1);
    nrd = 0;
    while (stallL2 && nrd < 200) begin @(negedge clk); #1; nrd++; end
    @(negedge clk);
    mem_wenable = 1'b0;
    chk("wdone_two_writes", n_wr - k, 2);
    ref_write(32'h48, 32'hCAFE_F00D);
    model_tx("rd48", 1, 0, 32'h48, 0);

    // Reset after the second fill beat abandons the fill; a late ack is ignored.
    k = 0;
    nwr = n_rd;
    mem_renable = 1'b1;
    mem_addr    = 32'h80;
    while (n_rd - nwr < 2 && k < 200) begin @(negedge clk); k++; end
    rst = 1'b0;
    dram_auto = 1'b0;
    dram_ack  = 1'b0;
    #1;
    chk("midfill_rst_stall", stallL2, 1'b0);
    chk("midfill_rst_req", dram_req, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    mem_renable = 1'b0;
    for (int i = 0; i < LINES; i++) ref_vld[i] = 1'b0;
    nrd = n_rd;
    #1;
    dram_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("late_ack_stall", stallL2, 1'b0);
    chk("late_ack_req", dram_req, 1'b0);
    chk("late_ack_nrd", n_rd - nrd, 0);
    dram_ack  = 1'b0;
    dram_auto = 1'b1;
    @(negedge clk);
    model_tx("post_rst_80", 1, 0, 32'h80, 0);
    model_tx("post_rst_40", 1, 0, 32'h40, 0);

    // Randomized traffic over a few tags on a handful of indices.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int          op;
      a  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      op = $urandom_range(0, 9);
      dram_lat = $urandom_range(1, 3);
      if (op < 5)      model_tx($sformatf("rnd%0d", i), 1, 0, a, 0);
      else if (op < 9) model_tx($sformatf("rnd%0d", i), 0, 1, a, $urandom);
      else             model_tx($sformatf("rnd%0d", i), 1, 1, a, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter LINES, default 16, meaning the number of direct-mapped lines; each line is 4 x 32-bit words; legal values are powers of two from 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port mem_renable, input, 1 bit: L1 block-read request, held by the requester until stallL2 is low.
REQ-005 SHALL have port mem_wenable, input, 1 bit: L1 word-write request (write-through), held by the requester until stallL2 is low.
REQ-006 SHALL have port mem_addr, input, 32 bits: request byte address; tag = [31:4+log2(LINES)], index = [3+log2(LINES):4], word = [3:2].
REQ-007 SHALL have port mem_wdata, input, 32 bits: write data.
REQ-008 SHALL have port l1block, output, 128 bits, ascending [0:127]: the addressed line; word0 in [0:31] through word3 in [96:127].
REQ-009 SHALL have port mem_rdata, output, 32 bits: the l1block word selected by mem_addr[3:2].
REQ-010 SHALL have port stallL2, output, 1 bit: high = request not yet served.
REQ-011 SHALL have ports dram_req (output, 1), dram_we (output, 1), dram_addr (output, 32), dram_wdata (output, 32), dram_rdata (input, 32) and dram_ack (input, 1): backing-memory handshake; a transfer completes on a clk edge with dram_req and dram_ack both high.

Function
REQ-012 SHALL implement FSM states IDLE, FILL, WRITE and WDONE.
REQ-013 In IDLE, a read that hits (valid line with matching tag) SHALL drive stallL2=0 and l1block=line combinationally (zero-latency hit); the FSM stays in IDLE.
REQ-014 In IDLE, a read miss SHALL drive stallL2=1 in the same cycle and move to FILL with beat counter 0.
REQ-015 FILL SHALL issue 4 DRAM reads to {mem_addr[31:4], beat, 2'b00} for beat 0..3 with dram_req=1 and dram_we=0, capturing dram_rdata into word[beat] on each ack.
REQ-016 On the 4th ack, FILL SHALL write the valid bit, tag and 4 words into the line in one edge and return to IDLE; the held read then hits in the next cycle.
REQ-017 In IDLE, a write (any hit status) SHALL drive stallL2=1 and move to WRITE.
REQ-018 WRITE SHALL drive dram_req=1, dram_we=1, dram_addr=mem_addr and dram_wdata=mem_wdata; on ack, if the line hits it SHALL update that word only (no write-allocate on a miss), then move to WDONE.
REQ-019 WDONE SHALL drive stallL2=0 for exactly one cycle, ignore all requests and return to IDLE.
REQ-020 stallL2 SHALL be 1 in FILL and WRITE, 0 in WDONE, and 0 in IDLE with no request.
REQ-021 If mem_renable and mem_wenable are both high, the read SHALL take priority and the write SHALL be ignored that cycle.
REQ-022 dram_ack outside FILL or WRITE SHALL be ignored; dram_req SHALL be 0 in IDLE and WDONE.
REQ-023 l1block and mem_rdata SHALL be 0 when the addressed line does not hit.
REQ-024 mem_addr and mem_wdata SHALL NOT change while stallL2=1; the block does not register them.

Reset
REQ-025 On rst=0, asynchronously: FSM=IDLE, beat counter=0, all valid bits=0, dram_req=0, dram_we=0, dram_addr=0, dram_wdata=0, stallL2=0, l1block=0, mem_rdata=0.
REQ-026 A reset during FILL or WRITE SHALL abandon the transfer with no partial line update; dram_ack arriving after release SHALL be ignored.
REQ-027 Tag and data arrays need not be reset; valid bits gate all hits.

Structure
REQ-028 A shared package SHALL hold LINE_WORDS=4, WORD_W=32, the FSM state enum, and the tag/index/word-offset field-width functions of LINES.
REQ-029 The valid/tag/data storage SHALL be one sub-module, l2_line_store, providing a combinational read port and a single write port that supports a full-line fill or a single-word update.

Verification
REQ-030 Read at 0x0000_0040 after reset -> stallL2=1; 4 DRAM reads to 0x40, 0x44, 0x48 and 0x4C (ack latency 2); the cycle after the 4th ack stallL2=0 and l1block holds the 4 returned words in order.
REQ-031 Repeat of that read -> stallL2=0 in the same cycle and no dram_req; mem_addr=0x48 -> mem_rdata=word2.
REQ-032 Write 0xDEADBEEF to 0x44 (hit) -> one DRAM write; WDONE one cycle; a following read of 0x44 hits with mem_rdata=0xDEADBEEF.
REQ-033 Write to 0x1000_0000 (miss) -> one DRAM write; a subsequent read of 0x1000_0000 misses and fills.
REQ-034 Read 0x0000_0440 (same index as 0x40, tag differs) -> fill evicts the old line; a read of 0x40 then misses.
REQ-035 rst=0 after the 2nd fill ack -> stallL2=0 and dram_req=0 immediately; the line stays invalid; a late dram_ack causes no state change.
